// File: rtl/uart_frame_controller_pkg.sv
// Shared constants for the UART frame controller: parser state encodings,
// error codes and the default frame start marker.
package uart_frame_controller_pkg;

    localparam logic [2:0] STATE_IDLE  = 3'd0;
    localparam logic [2:0] STATE_INDEX = 3'd1;
    localparam logic [2:0] STATE_COUNT = 3'd2;
    localparam logic [2:0] STATE_DATA  = 3'd3;
    localparam logic [2:0] STATE_CHECK = 3'd4;

    localparam logic [1:0] ERROR_CHECKSUM   = 2'd0;
    localparam logic [1:0] ERROR_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERROR_OVERFLOW   = 2'd2;
    localparam logic [1:0] ERROR_ZERO_COUNT = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h42;

    // Flops in the metastability chain ahead of the edge detector.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/uart_frame_controller_byte_strobe_sync.sv
// Brings a slow-domain "data ready" level into the local clock domain and
// emits a one-cycle strobe together with the data word captured at that edge.
module byte_strobe_sync
    import uart_frame_controller_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock_12mhz,
    input  logic             reset,
    input  logic             level,
    input  logic [WIDTH-1:0] data,
    output logic             strobe,
    output logic [WIDTH-1:0] captured
);

    // Bit SYNC_STAGES is the delayed copy used for rising-edge detection.
    logic [SYNC_STAGES:0] sync_chain;
    logic                 rise;

    assign rise = sync_chain[SYNC_STAGES-1] & ~sync_chain[SYNC_STAGES];

    // NOTE: non-blocking assignments so every flop samples pre-edge values; blocking would collapse the chain.
    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            sync_chain <= '0;
            strobe     <= 1'b0;
            captured   <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-1:0], level};
            strobe     <= rise;
            if (rise) begin
                captured <= data;
            end
        end
    end

endmodule

// File: rtl/uart_frame_controller.sv
// Parses SYNC/INDEX/COUNT/DATA/CHECKSUM frames from the UART receiver into
// pixel RAM writes, and drives host flow control from the display busy flag.
module uart_frame_controller
    import uart_frame_controller_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         ADDR_WIDTH     = 8,
    parameter int         LED_BYTES      = 192,
    parameter int         TIMEOUT_CYCLES = 12000
) (
    input  logic                  clock_12mhz,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    input  logic                  display_busy,
    output logic                  rts,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_write_address,
    output logic [7:0]            mem_write_data,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [1:0]            error_code
);

    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);

    logic                   byte_strobe;
    logic [7:0]             rx_byte;
    logic [2:0]             state;
    logic [7:0]             start_index;
    logic [7:0]             remaining;
    logic [7:0]             offset;
    logic [7:0]             checksum;
    logic                   overflow;
    logic [TIMER_WIDTH-1:0] timer;
    logic [8:0]             address;
    logic                   in_range;
    logic                   timeout_hit;

    byte_strobe_sync #(.WIDTH(8)) u_byte_strobe_sync (
        .clock_12mhz (clock_12mhz),
        .reset       (reset),
        .level       (rx_data_ready),
        .data        (rx_data),
        .strobe      (byte_strobe),
        .captured    (rx_byte)
    );

    // Nine-bit sum so a frame running past the buffer end is caught, never wrapped.
    assign address     = {1'b0, start_index} + {1'b0, offset};
    assign in_range    = int'(address) < LED_BYTES;
    assign timeout_hit = (state != STATE_IDLE) &&
                         (timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            rts <= 1'b0;
        end else begin
            rts <= ~display_busy;
        end
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            state             <= STATE_IDLE;
            start_index       <= '0;
            remaining         <= '0;
            offset            <= '0;
            checksum          <= '0;
            overflow          <= 1'b0;
            timer             <= '0;
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            frame_done        <= 1'b0;
            frame_error       <= 1'b0;
            error_code        <= ERROR_CHECKSUM;
        end else begin
            mem_write_enable <= 1'b0;
            frame_done       <= 1'b0;
            frame_error      <= 1'b0;

            // A strobe landing on the timeout cycle is dropped along with the frame.
            if (timeout_hit) begin
                frame_error <= 1'b1;
                error_code  <= ERROR_TIMEOUT;
                state       <= STATE_IDLE;
                timer       <= '0;
            end else if (byte_strobe) begin
                timer <= '0;
                case (state)
                    STATE_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state <= STATE_INDEX;
                        end
                    end
                    STATE_INDEX: begin
                        start_index <= rx_byte;
                        checksum    <= rx_byte;
                        state       <= STATE_COUNT;
                    end
                    STATE_COUNT: begin
                        if (rx_byte == 8'd0) begin
                            frame_error <= 1'b1;
                            error_code  <= ERROR_ZERO_COUNT;
                            state       <= STATE_IDLE;
                        end else begin
                            remaining <= rx_byte;
                            checksum  <= checksum ^ rx_byte;
                            offset    <= '0;
                            overflow  <= 1'b0;
                            state     <= STATE_DATA;
                        end
                    end
                    STATE_DATA: begin
                        if (in_range) begin
                            mem_write_enable  <= 1'b1;
                            mem_write_address <= ADDR_WIDTH'(address);
                            mem_write_data    <= rx_byte;
                        end else begin
                            overflow <= 1'b1;
                        end
                        checksum  <= checksum ^ rx_byte;
                        offset    <= offset + 8'd1;
                        remaining <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= STATE_CHECK;
                        end
                    end
                    STATE_CHECK: begin
                        if (rx_byte != checksum) begin
                            frame_error <= 1'b1;
                            error_code  <= ERROR_CHECKSUM;
                        end else if (overflow) begin
                            frame_error <= 1'b1;
                            error_code  <= ERROR_OVERFLOW;
                        end else begin
                            frame_done <= 1'b1;
                        end
                        state <= STATE_IDLE;
                    end
                    default: state <= STATE_IDLE;
                endcase
            end else if (state != STATE_IDLE) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule
